// File: rtl/ctr_pr_decode_pkg.sv
// ---------------------------------------------------------------------------
// ctr_pr_decode_pkg
//
// Purpose:
//   Shared definitions for the pseudo-random shift counter family
//   (ctr_pr4, ctr_pr5) and for the decoder that turns a sampled counter code
//   back into a binary step index. The file is `ifndef guarded so the
//   counters and the decoder can all pull it in without duplicate-definition
//   trouble.
//
// Contents:
//   - LUT_INIT constants for the N=4 and N=5 counters
//   - feedback tap positions into the counter output word
//   - depth of the hidden msb history register per counter width
//   - decoder FSM state enum
//   - small helpers: per-width lookups and an SB_LUT4-equivalent function
// ---------------------------------------------------------------------------
`ifndef CTR_PR_DECODE_PKG_SV
`define CTR_PR_DECODE_PKG_SV

package ctr_pr_decode_pkg;

  // Feedback truth tables. The 4-input LUT index is
  // {oldest msb history bit, top output bit, out[TAP_MID], out[TAP_LO]}.
  localparam logic [15:0] CTR_PR4_LUT_INIT = 16'h4B29;
  localparam logic [15:0] CTR_PR5_LUT_INIT = 16'hC34B;

  // The two low feedback taps are the same for both widths; the high tap is
  // always the top bit of the output word (see tap_hi below).
  localparam int TAP_LO  = 0;
  localparam int TAP_MID = 1;

  // Hidden msb history depth: the N=5 counter remembers one more shifted-out
  // msb than the N=4 counter does.
  localparam int CTR_PR4_MSB_DEPTH = 1;
  localparam int CTR_PR5_MSB_DEPTH = 2;

  // Defaults used by the decoder and its interface.
  localparam int DEFAULT_N         = 4;
  localparam int DEFAULT_MAX_STEPS = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // LUT contents for a given counter width.
  function automatic logic [15:0] lut_init(input int n);
    return (n == 5) ? CTR_PR5_LUT_INIT : CTR_PR4_LUT_INIT;
  endfunction

  // Msb history depth for a given counter width.
  function automatic int msb_depth(input int n);
    return (n == 5) ? CTR_PR5_MSB_DEPTH : CTR_PR4_MSB_DEPTH;
  endfunction

  // High feedback tap: the bit about to be shifted out.
  function automatic int tap_hi(input int n);
    return n - 1;
  endfunction

  // Same behaviour as an iCE40 SB_LUT4 cell: the 4-bit select picks one bit
  // of the 16-bit init vector.
  function automatic logic sb_lut4(input logic [15:0] init,
                                   input logic [3:0]  sel);
    return init[sel];
  endfunction

endpackage

`endif

// File: rtl/ctr_pr_decode_if.sv
// ---------------------------------------------------------------------------
// ctr_pr_decode_if
//
// Purpose:
//   Start/done handshake bundle between a requester and ctr_pr_decode.
//
// Signals:
//   start  requester -> decoder  one-cycle request
//   code   requester -> decoder  counter code, sampled with an accepted start
//   busy   decoder -> requester  high while searching
//   done   decoder -> requester  one-cycle result-valid pulse
//   idx    decoder -> requester  step index of the captured code
//   err    decoder -> requester  qualifies done: code not found
//
// Modports:
//   master  requester side
//   slave   decoder side
// ---------------------------------------------------------------------------
interface ctr_pr_decode_if
  import ctr_pr_decode_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int W = $clog2(DEFAULT_MAX_STEPS)
) ();

  logic         start;
  logic [N-1:0] code;
  logic         busy;
  logic         done;
  logic [W-1:0] idx;
  logic         err;

  modport master (
    output start, code,
    input  busy, done, idx, err
  );

  modport slave (
    input  start, code,
    output busy, done, idx, err
  );

endinterface

// File: rtl/ctr_pr_step.sv
// ---------------------------------------------------------------------------
// ctr_pr_step
//
// Purpose:
//   Combinational next state of a pseudo-random shift counter of width N
//   (4 or 5), i.e. exactly what ctr_pr4 / ctr_pr5 do on one inc pulse.
//   The feedback bit comes from an SB_LUT4-style table lookup and is shifted
//   in at the bottom; the bit shifted out of the top enters the hidden msb
//   history.
//
// Ports:
//   out_i  [N-1:0]  current counter output word
//   msb_i  [D-1:0]  current msb history (D = 1 for N=4, 2 for N=5)
//   out_o  [N-1:0]  output word after one step
//   msb_o  [D-1:0]  msb history after one step
// ---------------------------------------------------------------------------
module ctr_pr_step
  import ctr_pr_decode_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0]            out_i,
  input  logic [msb_depth(N)-1:0] msb_i,
  output logic [N-1:0]            out_o,
  output logic [msb_depth(N)-1:0] msb_o
);

  localparam int          D    = msb_depth(N);
  localparam int          HI   = tap_hi(N);
  localparam logic [15:0] INIT = lut_init(N);

  logic [3:0] lutSel;
  logic       lutBit;

  // The oldest history bit leads the LUT select, so for N=5 the feedback
  // depends on the msb shifted out two steps ago.
  assign lutSel = {msb_i[D-1], out_i[HI], out_i[TAP_MID], out_i[TAP_LO]};
  assign lutBit = sb_lut4(INIT, lutSel);

  assign out_o = {out_i[N-2:0], lutBit};

  // History is a tiny shift register fed by the outgoing msb.
  if (D == 1) begin : g_hist1
    assign msb_o = out_i[HI];
  end else begin : g_histn
    assign msb_o = {msb_i[D-2:0], out_i[HI]};
  end

endmodule

// File: rtl/ctr_pr_decode.sv
// ---------------------------------------------------------------------------
// ctr_pr_decode
//
// Purpose:
//   Converts a sampled ctr_pr4 / ctr_pr5 code into its binary step index
//   (number of inc pulses since the all-zero state). A private replica of
//   the counter is stepped from all-zero until its output equals the
//   captured code; the first matching step is reported. If nothing matches
//   within MAX_STEPS replica states, done is raised with err=1 and
//   idx=MAX_STEPS-1.
//
// Parameters:
//   N          counter width, 4 or 5
//   MAX_STEPS  replica states examined before giving up, 2..256
//   W          idx width, $clog2(MAX_STEPS) (derived)
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   dec_if  ctr_pr_decode_if.slave: start, code in; busy, done, idx, err out
//
// Build option:
//   CTR_PR_DECODE_FAST_EN  when defined, each search cycle checks both the
//   replica and its successor and advances two states, halving latency.
//   idx/err are identical in both builds.
// ---------------------------------------------------------------------------
module ctr_pr_decode
  import ctr_pr_decode_pkg::*;
#(
  parameter  int N         = DEFAULT_N,
  parameter  int MAX_STEPS = DEFAULT_MAX_STEPS,
  localparam int W         = $clog2(MAX_STEPS),
  localparam int D         = msb_depth(N)
) (
  input  logic           clk,
  input  logic           rst,
  ctr_pr_decode_if.slave dec_if
);

  // Only the two counter sequences the LUT tables describe are supported.
  if (!(N == 4 || N == 5)) begin : g_bad_n
    $error("ctr_pr_decode: N must be 4 or 5");
  end
  if (MAX_STEPS < 2 || MAX_STEPS > 256) begin : g_bad_max
    $error("ctr_pr_decode: MAX_STEPS must be in 2..256");
  end

  // Last replica index that may be examined, one bit wider than step so the
  // fast build can compare step+1 without wrapping.
  localparam logic [W:0] LAST_STEP = (W+1)'(MAX_STEPS - 1);

  state_e         state_q, state_d;
  logic [N-1:0]   code_q, code_d;
  logic [N-1:0]   repOut_q, repOut_d;
  logic [D-1:0]   repMsb_q, repMsb_d;
  logic [W-1:0]   step_q, step_d;
  logic [W-1:0]   idx_q, idx_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [W:0]     stepExt;
  logic [W:0]     stepNext;
  logic [N-1:0]   nxt1Out;
  logic [D-1:0]   nxt1Msb;

  assign stepExt  = {1'b0, step_q};
  assign stepNext = stepExt + 1'b1;

  // Successor of the replica; needed in both builds.
  ctr_pr_step #(.N(N)) u_step1 (
    .out_i (repOut_q),
    .msb_i (repMsb_q),
    .out_o (nxt1Out),
    .msb_o (nxt1Msb)
  );

`ifdef CTR_PR_DECODE_FAST_EN
  logic [N-1:0]   nxt2Out;
  logic [D-1:0]   nxt2Msb;
  logic [W:0]     stepTwo;

  assign stepTwo = stepExt + (W+1)'(2);

  // Second step in series: the state two inc pulses ahead, used to advance
  // the replica by two per cycle.
  ctr_pr_step #(.N(N)) u_step2 (
    .out_i (nxt1Out),
    .msb_i (nxt1Msb),
    .out_o (nxt2Out),
    .msb_o (nxt2Msb)
  );
`endif

  // Next-state and output logic. Everything holds by default; a start seen
  // in IDLE or DONE restarts the replica from all-zero with the new code,
  // and SEARCH either finishes (match or limit) or advances the replica.
  // busy/done are derived from the next state so they come out of flops
  // aligned with the state they describe.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    repOut_d = repOut_q;
    repMsb_d = repMsb_q;
    step_d   = step_q;
    idx_d    = idx_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (dec_if.start) begin
          code_d   = dec_if.code;
          repOut_d = '0;
          repMsb_d = '0;
          step_d   = '0;
          state_d  = ST_SEARCH;
        end else begin
          state_d  = ST_IDLE;
        end
      end

      ST_SEARCH: begin
`ifdef CTR_PR_DECODE_FAST_EN
        // The successor only counts while its index is still inside the
        // examined window, so odd MAX_STEPS gives the same answer as the
        // single-step build.
        if (repOut_q == code_q) begin
          idx_d   = step_q;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (nxt1Out == code_q && stepNext <= LAST_STEP) begin
          idx_d   = stepNext[W-1:0];
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (stepNext >= LAST_STEP) begin
          idx_d   = LAST_STEP[W-1:0];
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          repOut_d = nxt2Out;
          repMsb_d = nxt2Msb;
          step_d   = stepTwo[W-1:0];
        end
`else
        // A match on the very last examined state still wins over err.
        if (repOut_q == code_q) begin
          idx_d   = step_q;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (stepExt == LAST_STEP) begin
          idx_d   = LAST_STEP[W-1:0];
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          repOut_d = nxt1Out;
          repMsb_d = nxt1Msb;
          step_d   = stepNext[W-1:0];
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SEARCH);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers. Reset is asynchronous so an in-flight
  // search is dropped immediately and never produces a done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      code_q   <= '0;
      repOut_q <= '0;
      repMsb_q <= '0;
      step_q   <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      repOut_q <= repOut_d;
      repMsb_q <= repMsb_d;
      step_q   <= step_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign dec_if.busy = busy_q;
  assign dec_if.done = done_q;
  assign dec_if.idx  = idx_q;
  assign dec_if.err  = err_q;

endmodule
